edge_stamp_fifo: RTL and testbench



---
 rtl/edge_stamp_pkg.sv | 8 +
 rtl/stamp_fifo.sv | 55 +++++
 rtl/edge_stamp_fifo.sv | 74 +++++++
 tb/tb_edge_stamp_fifo.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_stamp_pkg.sv
// Shared widths and word layout for the edge timestamp FIFO.
// A buffered word is {edge_count, timestamp}, with the count in the MSBs.
package edge_stamp_pkg;
  localparam int CNT_WIDTH_DEF = 16;
  localparam int TS_WIDTH_DEF  = 32;
  localparam int WORD_W        = CNT_WIDTH_DEF + TS_WIDTH_DEF;
  localparam int COUNT_LSB     = TS_WIDTH_DEF;
endpackage

// File: rtl/stamp_fifo.sv
// Generic first-word-fall-through FIFO with registered pointers.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module stamp_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              clr,
  input  logic              push,
  input  logic [WIDTH-1:0]  din,
  input  logic              pop,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

  // Storage is not reset, so the head word is masked to zero while empty.
  assign dout = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/edge_stamp_fifo.sv
// Counts accepted encoder edges, stamps each with a free-running counter
// and buffers {count, timestamp} words for valid/ready readout.
module edge_stamp_fifo
  import edge_stamp_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int DEPTH     = 16,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                          clk_50M,
  input  logic                          arst,
  input  logic                          edge_in,
  input  logic                          en,
  input  logic                          clr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CNT_WIDTH+TS_WIDTH-1:0] m_data,
  output logic [ADDR_W:0]               fifo_level,
  output logic [CNT_WIDTH-1:0]          edge_count,
  output logic [TS_WIDTH-1:0]           timestamp,
  output logic                          overflow
);

  localparam int W_WORD = CNT_WIDTH + TS_WIDTH;

  logic                 accept;
  logic                 full;
  logic                 empty;
  logic                 pop_now;
  logic [CNT_WIDTH-1:0] count_next;
  logic [W_WORD-1:0]    word;

  assign accept     = edge_in & en & ~clr;
  assign pop_now    = m_ready & ~empty;
  assign count_next = edge_count + CNT_WIDTH'(1);
  assign word       = {count_next, timestamp};
  assign m_valid    = ~empty;

  always_ff @(posedge clk_50M or posedge arst) begin
    if (arst) begin
      timestamp  <= '0;
      edge_count <= '0;
      overflow   <= 1'b0;
    end else begin
      timestamp <= timestamp + TS_WIDTH'(1);
      if (clr) begin
        edge_count <= '0;
        overflow   <= 1'b0;
      end else if (accept) begin
        // The count advances even when the word is dropped, leaving a visible gap.
        edge_count <= count_next;
        if (full && !pop_now) overflow <= 1'b1;
      end
    end
  end

  stamp_fifo #(
    .WIDTH (W_WORD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_50M),
    .arst  (arst),
    .clr   (clr),
    .push  (accept),
    .din   (word),
    .pop   (m_ready),
    .dout  (m_data),
    .empty (empty),
    .full  (full),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_edge_stamp_fifo.sv
// Bench for edge_stamp_fifo: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_edge_stamp_fifo;

  logic        clk;
  logic        arst;
  logic        edge_in, en, clr, m_ready;
  logic        m_valid;
  logic [47:0] m_data;
  logic [4:0]  fifo_level;
  logic [15:0] edge_count;
  logic [31:0] timestamp;
  logic        overflow;

  logic        edge2, en2, clr2, rdy2;
  logic        valid2;
  logic [19:0] data2;
  logic [4:0]  level2;
  logic [15:0] count2;
  logic [3:0]  ts2;
  logic        ovf2;

  int checks = 0;
  int errors = 0;

  edge_stamp_fifo dut (
    .clk_50M(clk), .arst(arst), .edge_in(edge_in), .en(en), .clr(clr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_level(fifo_level), .edge_count(edge_count),
    .timestamp(timestamp), .overflow(overflow)
  );

  edge_stamp_fifo #(.TS_WIDTH(4)) dut2 (
    .clk_50M(clk), .arst(arst), .edge_in(edge2), .en(en2), .clr(clr2),
    .m_valid(valid2), .m_ready(rdy2), .m_data(data2),
    .fifo_level(level2), .edge_count(count2),
    .timestamp(ts2), .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: a plain queue of words plus counters
  logic [47:0] q[$];
  logic [15:0] m_cnt;
  logic [31:0] m_ts;
  logic        m_ovf;

  task automatic model_reset();
    q.delete();
    m_cnt = '0;
    m_ts  = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic [47:0] w;
    if (arst) begin
      model_reset();
    end else begin
      w = {m_cnt + 16'd1, m_ts};
      if (clr) begin
        q.delete();
        m_cnt = '0;
        m_ovf = 1'b0;
      end else begin
        if (m_ready && q.size() > 0) void'(q.pop_front());
        if (edge_in && en) begin
          m_cnt = m_cnt + 16'd1;
          if (q.size() < 16) q.push_back(w);
          else m_ovf = 1'b1;
        end
      end
      m_ts = m_ts + 32'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [47:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : 48'd0;
    chk({name, ".valid"}, 64'(m_valid), 64'(q.size() != 0));
    chk({name, ".data"}, 64'(m_data), 64'(exp_data));
    chk({name, ".level"}, 64'(fifo_level), 64'(q.size()));
    chk({name, ".count"}, 64'(edge_count), 64'(m_cnt));
    chk({name, ".ts"}, 64'(timestamp), 64'(m_ts));
    chk({name, ".ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic idle();
    edge_in = 1'b0; en = 1'b1; clr = 1'b0; m_ready = 1'b0;
  endtask

  typedef struct {
    logic        e, en, clr, rdy;
    logic        valid;
    logic [15:0] cf;
    logic [31:0] tf;
    logic [4:0]  lvl;
    logic [15:0] cnt;
    logic [31:0] ts;
    logic        ovf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #10_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev_ts;
    logic [15:0] saved_cnt;
    logic [4:0]  saved_lvl;
    logic [47:0] exp_w;
    bit          found;

    //           e     en    clr   rdy   valid cnt_f   ts_f    lvl   cnt     ts      ovf
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 32'd10, 5'd1, 16'd1, 32'd11, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0,  5'd0, 16'd1, 32'd12, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0,  5'd0, 16'd1, 32'd13, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 32'd13, 5'd1, 16'd2, 32'd14, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 32'd14, 5'd1, 16'd3, 32'd15, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'd0,  5'd0, 16'd0, 32'd16, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 32'd16, 5'd1, 16'd1, 32'd17, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0,  5'd0, 16'd1, 32'd18, 1'b0};

    edge2 = 1'b0; en2 = 1'b1; clr2 = 1'b0; rdy2 = 1'b0;
    idle();
    model_reset();
    arst = 1'b1;
    step(); step();
    arst = 1'b0;
    check_model("reset0");

    // Fill to full, then one more edge is dropped
    for (int i = 0; i < 16; i++) begin
      edge_in = 1'b1; step(); check_model("fill");
    end
    step();
    edge_in = 1'b0;
    chk("full.level", 64'(fifo_level), 64'd16);
    chk("full.ovf", 64'(overflow), 64'd1);
    chk("full.count", 64'(edge_count), 64'd17);
    m_ready = 1'b1;
    prev_ts = '0;
    for (int i = 0; i < 16; i++) begin
      chk("drain.count", 64'(m_data[47:32]), 64'(i + 1));
      if (i > 0) chk("drain.ts_incr", 64'(m_data[31:0] > prev_ts), 64'd1);
      prev_ts = m_data[31:0];
      step(); check_model("drain");
    end
    m_ready = 1'b0;

    // Full with simultaneous push and pop
    clr = 1'b1; step(); clr = 1'b0; check_model("clr1");
    edge_in = 1'b1;
    for (int i = 0; i < 16; i++) step();
    m_ready = 1'b1;
    step();
    edge_in = 1'b0; m_ready = 1'b0;
    chk("fullpp.level", 64'(fifo_level), 64'd16);
    chk("fullpp.ovf", 64'(overflow), 64'd0);
    check_model("fullpp");
    m_ready = 1'b1;
    exp_w = '0;
    for (int i = 0; i < 16; i++) begin
      exp_w = m_data;
      step();
    end
    m_ready = 1'b0;
    chk("fullpp.last", 64'(exp_w[47:32]), 64'd17);
    check_model("fullpp.empty");

    // en=0 ignores edges but the FIFO still holds/drains
    edge_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    edge_in = 1'b0; step();
    saved_cnt = edge_count; saved_lvl = fifo_level;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_in = 1'b1; step(); edge_in = 1'b0; step();
    end
    chk("en0.count", 64'(edge_count), 64'(saved_cnt));
    chk("en0.level", 64'(fifo_level), 64'(saved_lvl));
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check_model("en0.drain");
    en = 1'b1;

    // Randomized run
    for (int i = 0; i < 2000; i++) begin
      edge_in = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 9) != 0);
      clr     = ($urandom_range(0, 63) == 0);
      m_ready = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 30 : 70));
      step();
      check_model("rand");
    end

    // Clear with edge in same cycle while level=5
    idle();
    clr = 1'b1; step(); clr = 1'b0;
    edge_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("clr5.level_pre", 64'(fifo_level), 64'd5);
    clr = 1'b1; m_ready = 1'b1; step();
    clr = 1'b0; m_ready = 1'b0;
    chk("clr5.count", 64'(edge_count), 64'd0);
    chk("clr5.level", 64'(fifo_level), 64'd0);
    chk("clr5.valid", 64'(m_valid), 64'd0);
    chk("clr5.ovf", 64'(overflow), 64'd0);
    step(); edge_in = 1'b0;
    chk("clr5.next", 64'(m_data[47:32]), 64'd1);

    // Mid-run asynchronous reset after pushes
    edge_in = 1'b1; step(); step(); edge_in = 1'b0;
    arst = 1'b1;
    model_reset();
    #1;
    chk("arst.valid", 64'(m_valid), 64'd0);
    chk("arst.data", 64'(m_data), 64'd0);
    chk("arst.level", 64'(fifo_level), 64'd0);
    chk("arst.count", 64'(edge_count), 64'd0);
    chk("arst.ts", 64'(timestamp), 64'd0);
    chk("arst.ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) step();
    chk("arst.hold_ts", 64'(timestamp), 64'd0);
    arst = 1'b0;
    chk("rel.ts0", 64'(timestamp), 64'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("rel.ts", 64'(timestamp), 64'(k));
    end

    // Directed table starting with timestamp=10
    for (int i = 0; i < 8; i++) begin
      edge_in = tbl[i].e; en = tbl[i].en; clr = tbl[i].clr; m_ready = tbl[i].rdy;
      step();
      exp_w = tbl[i].valid ? {tbl[i].cf, tbl[i].tf} : 48'd0;
      chk($sformatf("tbl%0d.valid", i), 64'(m_valid), 64'(tbl[i].valid));
      chk($sformatf("tbl%0d.data", i), 64'(m_data), 64'(exp_w));
      chk($sformatf("tbl%0d.level", i), 64'(fifo_level), 64'(tbl[i].lvl));
      chk($sformatf("tbl%0d.count", i), 64'(edge_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d.ts", i), 64'(timestamp), 64'(tbl[i].ts));
      chk($sformatf("tbl%0d.ovf", i), 64'(overflow), 64'(tbl[i].ovf));
    end
    idle();

    // Narrow timestamp wraps and an edge at the wrap is stamped 0
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ts2 == 4'd15) found = 1'b1;
      else step();
    end
    chk("wrap.reach15", 64'(found), 64'd1);
    step();
    chk("wrap.ts0", 64'(ts2), 64'd0);
    edge2 = 1'b1; step(); edge2 = 1'b0;
    chk("wrap.valid", 64'(valid2), 64'd1);
    chk("wrap.data", 64'(data2), 64'({16'd1, 4'd0}));
    chk("wrap.level", 64'(level2), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
